// File: rtl/rtc_alarm_bank_if.sv
// Register bus between the RTC register decoder (master) and the alarm bank (slave).
// Signal names follow the RTC register bus naming.
interface rtc_alarm_bank_if;
  logic        wr_en_i;
  logic        rd_en_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic [31:0] rdata_o;

  modport master (output wr_en_i, rd_en_i, addr_i, wdata_i, input rdata_o);
  modport slave  (input wr_en_i, rd_en_i, addr_i, wdata_i, output rdata_o);
endinterface

// File: rtl/rtc_alarm_bank.sv
// Multi-channel RTC alarm unit: per-field masked compare, one-shot/periodic, sticky pending, level irq.
// Optional feature macro: RTC_ALARM_OVERRUN_EN (adds the W1C OVERRUN flags).
module rtc_alarm_bank #(
  parameter int          N_ALARMS  = 4,
  parameter logic [31:0] BASE_ADDR = 32'h80,
  parameter int          YEAR_W    = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tick_i,
  input  logic [5:0]        cur_sec_i,
  input  logic [5:0]        cur_min_i,
  input  logic [6:0]        cur_hours_i,
  input  logic [2:0]        cur_dow_i,
  input  logic [4:0]        cur_dom_i,
  input  logic [3:0]        cur_month_i,
  input  logic [YEAR_W-1:0] cur_year_i,
  rtc_alarm_bank_if.slave   bus,
  output logic              irq_o
);

  localparam logic [31:0] WIN_END = 32'(16 + 16 * N_ALARMS);

  logic [5:0]        a_sec   [N_ALARMS];
  logic [5:0]        a_min   [N_ALARMS];
  logic [6:0]        a_hours [N_ALARMS];
  logic [2:0]        a_dow   [N_ALARMS];
  logic [4:0]        a_dom   [N_ALARMS];
  logic [3:0]        a_month [N_ALARMS];
  logic [YEAR_W-1:0] a_year  [N_ALARMS];
  logic [6:0]        mask    [N_ALARMS];
  logic [N_ALARMS-1:0] en, periodic, ie, pending, match, ch_wr, status_clr;

  logic [31:0] off;
  logic [3:0]  ch_sel;
  logic [1:0]  reg_sel;
  logic        ch_hit;
  logic [31:0] rd_val;
  logic        unused_bits;

  assign off     = bus.addr_i - BASE_ADDR;
  assign ch_hit  = (off >= 32'h10) && (off < WIN_END);
  assign ch_sel  = 4'((off - 32'h10) >> 4);
  assign reg_sel = off[3:2];
  assign status_clr = (bus.wr_en_i && off == 32'h0) ? bus.wdata_i[N_ALARMS-1:0] : '0;
  // Sink for address/data bits that no register field decodes.
  assign unused_bits = ^{bus.wdata_i, off};

  always_comb begin
    ch_wr = '0;
    match = '0;
    for (int k = 0; k < N_ALARMS; k++) begin
      ch_wr[k] = bus.wr_en_i && ch_hit && (ch_sel == 4'(k));
      match[k] = tick_i && en[k]
              && (!mask[k][0] || a_sec[k]   == cur_sec_i)
              && (!mask[k][1] || a_min[k]   == cur_min_i)
              && (!mask[k][2] || a_hours[k] == cur_hours_i)
              && (!mask[k][3] || a_dow[k]   == cur_dow_i)
              && (!mask[k][4] || a_dom[k]   == cur_dom_i)
              && (!mask[k][5] || a_month[k] == cur_month_i)
              && (!mask[k][6] || a_year[k]  == cur_year_i);
    end
  end

`ifdef RTC_ALARM_OVERRUN_EN
  logic [N_ALARMS-1:0] overrun, overrun_clr;
  assign overrun_clr = (bus.wr_en_i && off == 32'h4) ? bus.wdata_i[N_ALARMS-1:0] : '0;

  // A W1C of pending in the match cycle also suppresses the overrun report.
  always_ff @(posedge clk) begin
    if (rst) overrun <= '0;
    else     overrun <= (overrun & ~overrun_clr) | (match & pending & ~status_clr);
  end
`endif

  always_comb begin
    rd_val = '0;
    if (off == 32'h0) begin
      rd_val[N_ALARMS-1:0] = pending;
    end
`ifdef RTC_ALARM_OVERRUN_EN
    else if (off == 32'h4) begin
      rd_val[N_ALARMS-1:0] = overrun;
    end
`endif
    for (int k = 0; k < N_ALARMS; k++) begin
      if (ch_hit && ch_sel == 4'(k)) begin
        case (reg_sel)
          2'd0: begin
            rd_val[5:0]   = a_sec[k];
            rd_val[13:8]  = a_min[k];
            rd_val[22:16] = a_hours[k];
          end
          2'd1: begin
            rd_val[2:0]          = a_dow[k];
            rd_val[12:8]         = a_dom[k];
            rd_val[19:16]        = a_month[k];
            rd_val[24 +: YEAR_W] = a_year[k];
          end
          2'd2: rd_val[6:0] = mask[k];
          default: rd_val[2:0] = {ie[k], periodic[k], en[k]};
        endcase
      end
    end
  end

  // A new match wins over a same-cycle W1C; a CTRL write wins over the one-shot auto-clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending  <= '0;
      en       <= '0;
      periodic <= '0;
      ie       <= '0;
      for (int k = 0; k < N_ALARMS; k++) begin
        a_sec[k]   <= '0;
        a_min[k]   <= '0;
        a_hours[k] <= '0;
        a_dow[k]   <= '0;
        a_dom[k]   <= '0;
        a_month[k] <= '0;
        a_year[k]  <= '0;
        mask[k]    <= '0;
      end
    end else begin
      pending <= (pending & ~status_clr) | match;
      for (int k = 0; k < N_ALARMS; k++) begin
        if (ch_wr[k] && reg_sel == 2'd0) begin
          a_sec[k]   <= bus.wdata_i[5:0];
          a_min[k]   <= bus.wdata_i[13:8];
          a_hours[k] <= bus.wdata_i[22:16];
        end
        if (ch_wr[k] && reg_sel == 2'd1) begin
          a_dow[k]   <= bus.wdata_i[2:0];
          a_dom[k]   <= bus.wdata_i[12:8];
          a_month[k] <= bus.wdata_i[19:16];
          a_year[k]  <= bus.wdata_i[24 +: YEAR_W];
        end
        if (ch_wr[k] && reg_sel == 2'd2) begin
          mask[k] <= bus.wdata_i[6:0];
        end
        if (ch_wr[k] && reg_sel == 2'd3) begin
          en[k]       <= bus.wdata_i[0];
          periodic[k] <= bus.wdata_i[1];
          ie[k]       <= bus.wdata_i[2];
        end else if (match[k] && !periodic[k]) begin
          en[k] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.rdata_o <= '0;
      irq_o       <= 1'b0;
    end else begin
      if (bus.rd_en_i) bus.rdata_o <= rd_val;
      irq_o <= |(pending & ie);
    end
  end

endmodule

// File: tb/tb_rtc_alarm_bank.sv
// Randomized + directed bench for rtc_alarm_bank, checked against a field-list reference model.
// Honours RTC_ALARM_OVERRUN_EN when building expectations.
module tb_rtc_alarm_bank;
  localparam int          N    = 4;
  localparam logic [31:0] BASE = 32'h80;
  localparam int          YW   = 7;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          tick = 1'b0;
  logic [5:0]    cur_sec = '0, cur_min = '0;
  logic [6:0]    cur_hours = '0;
  logic [2:0]    cur_dow = '0;
  logic [4:0]    cur_dom = '0;
  logic [3:0]    cur_month = '0;
  logic [YW-1:0] cur_year = '0;
  logic          irq;

  rtc_alarm_bank_if bus ();

  rtc_alarm_bank #(.N_ALARMS(N), .BASE_ADDR(BASE), .YEAR_W(YW)) dut (
    .clk(clk), .rst(rst), .tick_i(tick),
    .cur_sec_i(cur_sec), .cur_min_i(cur_min), .cur_hours_i(cur_hours),
    .cur_dow_i(cur_dow), .cur_dom_i(cur_dom), .cur_month_i(cur_month),
    .cur_year_i(cur_year), .bus(bus.slave), .irq_o(irq)
  );

  always #5 clk = ~clk;

  // Reference model: each channel holds a list of 7 field values (sec..year) plus flags.
  int          fld [N][7];
  int          msk [N];
  bit          m_en [N], m_per [N], m_ie [N], m_pend [N], m_ovr [N];
  logic [31:0] exp_rdata;
  logic        exp_irq;
  int          vectors = 0;
  int          miscompares = 0;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", tag, observed, expected, $time);
    end
  endtask

  function automatic logic [31:0] chanAddr(int k, int r);
    return BASE + 32'(16 + 16 * k + 4 * r);
  endfunction

  function automatic logic [31:0] modelRead(logic [31:0] a);
    logic [31:0] r = 0;
    int k;
    if (a == BASE) begin
      for (int i = 0; i < N; i++) if (m_pend[i]) r += 32'(1) << i;
    end else if (a == BASE + 4) begin
`ifdef RTC_ALARM_OVERRUN_EN
      for (int i = 0; i < N; i++) if (m_ovr[i]) r += 32'(1) << i;
`endif
    end else if (a >= BASE + 16 && a < BASE + 32'(16 + 16 * N)) begin
      k = int'((a - BASE - 16) / 16);
      case (int'(((a - BASE) % 16) / 4))
        0: r = 32'(fld[k][0] + fld[k][1] * 256 + fld[k][2] * 65536);
        1: r = 32'(fld[k][3] + fld[k][4] * 256 + fld[k][5] * 65536) + (32'(fld[k][6]) << 24);
        2: r = 32'(msk[k]);
        default: r = 32'(int'(m_en[k]) + 2 * int'(m_per[k]) + 4 * int'(m_ie[k]));
      endcase
    end
    return r;
  endfunction

  task automatic modelEdge();
    int  cur [7];
    bit  new_irq = 0;
    bit  hit, clr, oclr, old_pend;
    int  k, r;
    logic [31:0] a, d;
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        for (int f = 0; f < 7; f++) fld[i][f] = 0;
        msk[i] = 0; m_en[i] = 0; m_per[i] = 0; m_ie[i] = 0; m_pend[i] = 0; m_ovr[i] = 0;
      end
      exp_rdata = 0;
      exp_irq = 0;
      return;
    end
    a = bus.addr_i;
    d = bus.wdata_i;
    for (int i = 0; i < N; i++) if (m_pend[i] && m_ie[i]) new_irq = 1;
    if (bus.rd_en_i) exp_rdata = modelRead(a);
    cur = '{int'(cur_sec), int'(cur_min), int'(cur_hours), int'(cur_dow),
            int'(cur_dom), int'(cur_month), int'(cur_year)};
    for (int i = 0; i < N; i++) begin
      hit = tick && m_en[i];
      for (int f = 0; f < 7; f++) if (msk[i][f] && fld[i][f] != cur[f]) hit = 0;
      clr  = bus.wr_en_i && a == BASE && d[i];
      oclr = bus.wr_en_i && a == BASE + 4 && d[i];
      old_pend = m_pend[i];
      if (oclr) m_ovr[i] = 0;
      if (hit) begin
        if (old_pend && !clr) m_ovr[i] = 1;
        m_pend[i] = 1;
        if (!m_per[i]) m_en[i] = 0;
      end else if (clr) begin
        m_pend[i] = 0;
      end
    end
    if (bus.wr_en_i && a >= BASE + 16 && a < BASE + 32'(16 + 16 * N)) begin
      k = int'((a - BASE - 16) / 16);
      r = int'(((a - BASE) % 16) / 4);
      case (r)
        0: begin fld[k][0] = int'(d[5:0]); fld[k][1] = int'(d[13:8]); fld[k][2] = int'(d[22:16]); end
        1: begin
          fld[k][3] = int'(d[2:0]); fld[k][4] = int'(d[12:8]);
          fld[k][5] = int'(d[19:16]); fld[k][6] = int'(d[24 +: YW]);
        end
        2: msk[k] = int'(d[6:0]);
        default: begin m_en[k] = d[0]; m_per[k] = d[1]; m_ie[k] = d[2]; end
      endcase
    end
    exp_irq = new_irq;
  endtask

  // One clock: model follows the edge, outputs sampled 1 time unit later, strobes dropped.
  task automatic applyStimulus();
    @(posedge clk);
    modelEdge();
    #1;
    checkOutput("irq", 32'(irq), 32'(exp_irq));
    checkOutput("rdata", bus.rdata_o, exp_rdata);
    rst = 0; tick = 0; bus.wr_en_i = 0; bus.rd_en_i = 0;
  endtask

  task automatic writeReg(input logic [31:0] a, input logic [31:0] d);
    bus.addr_i = a; bus.wdata_i = d; bus.wr_en_i = 1;
    applyStimulus();
  endtask

  task automatic readExpect(input string tag, input logic [31:0] a, input logic [31:0] expected);
    bus.addr_i = a; bus.rd_en_i = 1;
    applyStimulus();
    checkOutput(tag, bus.rdata_o, expected);
  endtask

  task automatic setTime(int s, int m, int h, int dw, int dm, int mo, int y);
    cur_sec = 6'(s); cur_min = 6'(m); cur_hours = 7'(h); cur_dow = 3'(dw);
    cur_dom = 5'(dm); cur_month = 4'(mo); cur_year = YW'(y);
  endtask

  task automatic doTick();
    tick = 1;
    applyStimulus();
  endtask

  function automatic logic [31:0] randAddr();
    int sel = int'($urandom_range(0, 9));
    if (sel < 2) return BASE;
    if (sel == 2) return BASE + 4;
    if (sel == 3) return (sel == 3 && $urandom_range(0, 1) == 1) ? BASE + 8 : BASE + 32'(16 + 16 * N + 4 * $urandom_range(0, 3));
    return chanAddr(int'($urandom_range(0, N - 1)), int'($urandom_range(0, 3)));
  endfunction

  function automatic logic [31:0] randData(logic [31:0] a);
    logic [31:0] v = $urandom;
    if (a >= BASE + 16 && a < BASE + 32'(16 + 16 * N) && a[3:2] == 2'd0)
      v = ($urandom & 32'hFF80C0C0) | 32'($urandom_range(0, 2)) | (32'($urandom_range(0, 1)) << 8)
          | (($urandom_range(0, 1) == 1 ? 32'h45 : 32'h05) << 16);
    else if (a >= BASE + 16 && a < BASE + 32'(16 + 16 * N) && a[3:2] == 2'd1)
      v = ($urandom & 32'h80F0E0F8) | 32'($urandom_range(0, 1)) | (32'($urandom_range(0, 1)) << 8)
          | (32'($urandom_range(0, 1)) << 16) | (32'($urandom_range(0, 1)) << 24);
    return v;
  endfunction

  logic [31:0] ovr_after_three;

  initial begin
    bus.wr_en_i = 0; bus.rd_en_i = 0; bus.addr_i = 0; bus.wdata_i = 0;
    rst = 1;
    applyStimulus();
    for (int a = 0; a < 4 + 4 * (N + 1); a++) readExpect("reset_reg", BASE + 32'(4 * a), 32'h0);
    checkOutput("reset_irq", 32'(irq), 32'h0);

    // Ch0 one-shot on sec=30 with ie
    writeReg(chanAddr(0, 0), 32'd30);
    writeReg(chanAddr(0, 2), 32'h01);
    writeReg(chanAddr(0, 3), 32'h5);
    setTime(29, 0, 0, 0, 0, 0, 0);
    doTick();
    readExpect("ch0_no_match", BASE, 32'h0);
    setTime(30, 0, 0, 0, 0, 0, 0);
    doTick();
    checkOutput("ch0_irq_lag", 32'(irq), 32'h0);
    readExpect("ch0_pending", BASE, 32'h1);
    checkOutput("ch0_irq", 32'(irq), 32'h1);
    readExpect("ch0_ctrl_oneshot", chanAddr(0, 3), 32'h4);
    writeReg(BASE, 32'h1);
    applyStimulus();
    checkOutput("ch0_irq_clr", 32'(irq), 32'h0);

    // Ch1 periodic, mask 0, no ie
    writeReg(chanAddr(1, 3), 32'h3);
    for (int i = 0; i < 3; i++) doTick();
    applyStimulus();
    checkOutput("ch1_irq_off", 32'(irq), 32'h0);
    readExpect("ch1_pending", BASE, 32'h2);
`ifdef RTC_ALARM_OVERRUN_EN
    ovr_after_three = 32'h2;
`else
    ovr_after_three = 32'h0;
`endif
    readExpect("ch1_overrun", BASE + 4, ovr_after_three);
    writeReg(chanAddr(1, 3), 32'h0);
    writeReg(BASE, 32'h2);
    writeReg(BASE + 4, 32'hF);
    readExpect("ch1_cleared", BASE, 32'h0);

    // Ch2 full match incl. hour mode bits
    writeReg(chanAddr(2, 0), 32'd10 | (32'd20 << 8) | (32'h45 << 16));
    writeReg(chanAddr(2, 1), 32'd3 | (32'd15 << 8) | (32'd6 << 16) | (32'd24 << 24));
    writeReg(chanAddr(2, 2), 32'h7F);
    writeReg(chanAddr(2, 3), 32'h1);
    setTime(10, 20, 'h05, 3, 15, 6, 24);
    doTick();
    readExpect("ch2_mode_mismatch", BASE, 32'h0);
    setTime(10, 20, 'h45, 3, 15, 6, 24);
    doTick();
    readExpect("ch2_pending", BASE, 32'h4);
    writeReg(BASE, 32'h4);

    // Ch0 periodic match colliding with its W1C
    writeReg(chanAddr(0, 3), 32'h7);
    setTime(30, 0, 0, 0, 0, 0, 0);
    doTick();
    applyStimulus();
    tick = 1;
    writeReg(BASE, 32'h1);
    readExpect("w1c_loses", BASE, 32'h1);
    checkOutput("w1c_irq_held", 32'(irq), 32'h1);
    readExpect("w1c_no_overrun", BASE + 4, 32'h0);
    writeReg(chanAddr(0, 3), 32'h0);
    writeReg(BASE, 32'h1);

    // Ch3 armed, reset together with matching tick
    writeReg(chanAddr(3, 0), 32'd5);
    writeReg(chanAddr(3, 2), 32'h1);
    writeReg(chanAddr(3, 3), 32'h5);
    setTime(5, 0, 0, 0, 0, 0, 0);
    rst = 1; tick = 1;
    applyStimulus();
    for (int a = 0; a < 4 + 4 * (N + 1); a++) readExpect("rst2_reg", BASE + 32'(4 * a), 32'h0);
    checkOutput("rst2_irq", 32'(irq), 32'h0);
    doTick();
    readExpect("rst2_disarmed", BASE, 32'h0);

    // Unmapped read after a non-zero read
    writeReg(chanAddr(0, 2), 32'hFFFF_FFFF);
    readExpect("mask_bits", chanAddr(0, 2), 32'h7F);
    readExpect("unmapped_end", BASE + 32'(16 + 16 * N), 32'h0);
    readExpect("mask_hold", chanAddr(0, 2), 32'h7F);
    readExpect("unmapped_gap", BASE + 8, 32'h0);

    // Randomized traffic; every cycle compared against the model
    for (int cyc = 0; cyc < 3000; cyc++) begin
      setTime(int'($urandom_range(0, 2)), int'($urandom_range(0, 1)),
              ($urandom_range(0, 1) == 1) ? 'h45 : 'h05, int'($urandom_range(0, 1)),
              int'($urandom_range(0, 1)), int'($urandom_range(0, 1)), int'($urandom_range(0, 1)));
      tick = ($urandom_range(0, 1) == 1);
      rst  = ($urandom_range(0, 399) == 0);
      if ($urandom_range(0, 2) == 0) begin
        bus.addr_i = randAddr();
        bus.wdata_i = randData(bus.addr_i);
        bus.wr_en_i = 1;
      end
      if ($urandom_range(0, 1) == 0) begin
        if (!bus.wr_en_i || $urandom_range(0, 3) != 0) bus.addr_i = randAddr();
        bus.rd_en_i = 1;
      end
      applyStimulus();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/rtc_alarm_bank.md
# rtc_alarm_bank

Parametrised multi-channel alarm unit for the RTC. It replaces the single fixed interrupt-in/interrupt-out time compare pair with N_ALARMS independent channels. Each channel has per-field match masks, one-shot or periodic mode, sticky pending flags and a combined interrupt. It sits beside the RTC timekeeping core, consumes the current-time fields and a once-per-update tick, and is reached through the RTC register bus.

## Interface
- N_ALARMS, 4: number of alarm channels, 1..16.
- BASE_ADDR, 32'h80: byte address of the alarm register window.
- YEAR_W, 7: width of the year field.

- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- tick_i  in  1  one-cycle pulse; the cur_* fields hold a new, stable time value in this cycle.
- cur_sec_i  in  6  current seconds, 0..59.
- cur_min_i  in  6  current minutes, 0..59.
- cur_hours_i  in  7  {mode_AM_PM, mode_12_24, hours[4:0]}.
- cur_dow_i  in  3  day of week.
- cur_dom_i  in  5  day of month.
- cur_month_i  in  4  month.
- cur_year_i  in  YEAR_W  year.
- wr_en_i  in  1  register write strobe.
- rd_en_i  in  1  register read strobe.
- addr_i  in  32  byte address, word aligned.
- wdata_i  in  32  write data.
- rdata_o  out  32  read data, valid one cycle after rd_en_i.
- irq_o  out  1  level interrupt: OR over channels of (pending & ie).

## Operation
- Global STATUS register, BASE_ADDR+0x0:
  - [N_ALARMS-1:0] pending flags.
  - Write-1-to-clear (W1C).
- Global OVERRUN register, BASE_ADDR+0x4: [N_ALARMS-1:0], W1C.
- Channel k occupies BASE_ADDR+0x10+0x10*k:
  - +0x0 TIME: sec[5:0], min[13:8], hours[22:16].
  - +0x4 DATE: dow[2:0], dom[12:8], month[19:16], year[24+YEAR_W-1:24].
  - +0x8 MASK: [6:0] = compare-enable per field, in order sec, min, hours, dow, dom, month, year.
  - +0xC CTRL: [0] en, [1] periodic, [2] ie.
- Unmapped or unimplemented bits read 0; writes to them are ignored.
- Match for channel k:
  - Evaluated only in a cycle with tick_i=1 and en=1.
  - Match = every field whose MASK bit is 1 equals the corresponding cur_* field.
  - MASK=0 matches on every tick.
  - The hours compare covers all 7 bits, including mode bits.
- On a match:
  - pending[k] is set.
  - If pending[k] was already 1, overrun[k] is also set.
  - If periodic=0, en is cleared at the same edge (one-shot).
  - If periodic=1, en stays 1.
- Simultaneous events:
  - A W1C of pending[k] in the match cycle loses; pending stays 1. Overrun is not set in this case.
  - A CTRL write in the match cycle takes priority over the one-shot auto-clear of en.
  - Writes to TIME/DATE/MASK in the match cycle take effect after that compare; the compare uses the old values.
- Clearing en does not clear pending.
- Reset values:
  - All registers 0.
  - rdata_o=0, irq_o=0.
- A reset asserted mid-operation clears all state at the next edge. A tick arriving during reset is dropped.

## Timing
- Writes take effect at the edge sampling wr_en_i.
- Reads:
  - rdata_o is registered and valid in the cycle after rd_en_i.
  - rdata_o holds its value until the next read.
  - A read and a write to the same address in the same cycle return the pre-write value.
- Pending is set at the edge that samples tick_i=1.
- irq_o is registered: it rises one cycle after pending is set (two edges after the tick cycle) and falls one cycle after the last qualifying pending or ie is cleared.
- No backpressure. tick_i spacing of 1 cycle (back-to-back) must be supported.

## Configuration
- RTC_ALARM_OVERRUN_EN defined:
  - OVERRUN register and flags are implemented as described.
- RTC_ALARM_OVERRUN_EN undefined:
  - No overrun storage; OVERRUN reads 0 and writes are ignored.
  - Repeated matches while pending only keep pending at 1.

## Test plan
- Ch0: TIME sec=30, MASK=0x01, CTRL=0x5 (one-shot, ie). Tick with sec=29, then sec=30 -> pending[0]=1 after the sec=30 tick; irq_o=1 one cycle later; CTRL reads 0x4.
- Ch1: periodic, MASK=0x00, ie=0. Three consecutive ticks -> pending[1]=1, irq_o stays 0; with the macro, OVERRUN=0x2. Write STATUS=0x2 -> pending[1]=0.
- Ch2: full match, MASK=0x7F, 2024 date with hours=7'h45 (PM, 12h, 5). Tick with the matching fields except hours=7'h05 -> no pending. Tick with hours=7'h45 -> pending[2]=1.
- Ch0 matches in the same cycle as a STATUS W1C of 0x1 -> pending[0] remains 1 and irq_o remains 1.
- Ch3 armed, rst pulsed for 1 cycle together with a matching tick -> all registers read 0 and irq_o=0; the next matching tick does nothing because en=0.
- Read of BASE_ADDR+0x10+0x10*N_ALARMS (unmapped) -> rdata_o=0 the next cycle.
